// File: rtl/present80_decrypt.sv
// PRESENT-80 block decryption core: expands the user key forward to K32,
// then walks 31 inverse rounds back down to K1 to recover the plaintext.
module present80_decrypt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] ciphertext,
    input  logic [79:0] key_input,
    output logic [63:0] plaintext,
    output logic        ready
);

    typedef enum logic [2:0] {
        IDLE,
        KEY_EXP,
        INIT,
        INV_ROUND,
        DONE
    } state_e;

    state_e      current_state_q, current_state_d;
    logic [63:0] state_q, state_d;
    logic [79:0] key_reg_q, key_reg_d;
    logic [4:0]  round_counter_q, round_counter_d;
    logic [63:0] plaintext_q, plaintext_d;
    logic        ready_q, ready_d;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [79:0] key_fwd(
        input logic [79:0] k,
        input logic [4:0]  i
    );
        logic [79:0] t;
        t = {k[18:0], k[79:19]};
        t[79:76] = sbox(t[79:76]);
        t[19:15] = t[19:15] ^ i;
        return t;
    endfunction

    function automatic logic [79:0] key_inv(
        input logic [79:0] k,
        input logic [4:0]  i
    );
        logic [79:0] t;
        t = k;
        t[19:15] = t[19:15] ^ i;
        t[79:76] = inv_sbox(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

    // Undo pLayer: output bit j is fed from bit 16*j mod 63.
    function automatic logic [63:0] inv_round(
        input logic [63:0] s,
        input logic [63:0] rk
    );
        logic [63:0] p;
        logic [63:0] o;
        for (int j = 0; j < 63; j++) begin
            p[j] = s[(16 * j) % 63];
        end
        p[63] = s[63];
        for (int n = 0; n < 16; n++) begin
            o[4*n +: 4] = inv_sbox(p[4*n +: 4]);
        end
        return o ^ rk;
    endfunction

    always_comb begin
        current_state_d = current_state_q;
        state_d         = state_q;
        key_reg_d       = key_reg_q;
        round_counter_d = round_counter_q;
        plaintext_d     = plaintext_q;
        ready_d         = ready_q;
        unique case (current_state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d         = ciphertext;
                    key_reg_d       = key_input;
                    round_counter_d = 5'd1;
                    ready_d         = 1'b0;
                    current_state_d = KEY_EXP;
                end
            end
            KEY_EXP: begin
                key_reg_d = key_fwd(key_reg_q, round_counter_q);
                if (round_counter_q == 5'd31) begin
                    current_state_d = INIT;
                end else begin
                    round_counter_d = round_counter_q + 5'd1;
                end
            end
            INIT: begin
                state_d         = state_q ^ key_reg_q[79:16];
                key_reg_d       = key_inv(key_reg_q, 5'd31);
                round_counter_d = 5'd31;
                current_state_d = INV_ROUND;
            end
            INV_ROUND: begin
                // Counter 0 marks the final edge that publishes the result.
                if (round_counter_q == 5'd0) begin
                    plaintext_d     = state_q;
                    ready_d         = 1'b1;
                    current_state_d = DONE;
                end else begin
                    state_d = inv_round(state_q, key_reg_q[79:16]);
                    if (round_counter_q != 5'd1) begin
                        key_reg_d = key_inv(key_reg_q,
                                            round_counter_q - 5'd1);
                    end
                    round_counter_d = round_counter_q - 5'd1;
                end
            end
            default: begin
                current_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_state_q <= IDLE;
            state_q         <= '0;
            key_reg_q       <= '0;
            round_counter_q <= '0;
            plaintext_q     <= '0;
            ready_q         <= 1'b0;
        end else begin
            current_state_q <= current_state_d;
            state_q         <= state_d;
            key_reg_q       <= key_reg_d;
            round_counter_q <= round_counter_d;
            plaintext_q     <= plaintext_d;
            ready_q         <= ready_d;
        end
    end

    assign plaintext = plaintext_q;
    assign ready     = ready_q;

endmodule
